// File: rtl/uart_rx_fifo_if.sv
// Byte-side and line-side signals of the UART receiver FIFO.
// The consumer side (master) drives the serial line and pop requests.
// The receiver (slave) returns the head byte, occupancy flags and error pulses.
// RD_EN/EMPTY handshake: a byte is consumed on a rising CLK edge where RD_EN=1
// and EMPTY=0; RD_DATA is the byte consumed and is valid whenever EMPTY=0.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  UART_IN;
  logic                  RD_EN;
  logic [7:0]            RD_DATA;
  logic                  EMPTY;
  logic                  FULL;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  FRAME_ERR;
  logic                  OVERFLOW;

  modport master (
    output UART_IN, RD_EN,
    input  RD_DATA, EMPTY, FULL, COUNT, FRAME_ERR, OVERFLOW
  );

  modport slave (
    input  UART_IN, RD_EN,
    output RD_DATA, EMPTY, FULL, COUNT, FRAME_ERR, OVERFLOW
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead circular byte FIFO.
// Received bytes are written on the stop-bit sample edge, so EMPTY/COUNT/
// RD_DATA and the FRAME_ERR/OVERFLOW pulses all change on that same edge.
// dbg_state exposes the receiver FSM state (IDLE=0 .. WAIT_HIGH=4).
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  uart_rx_fifo_if.slave     bus,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]         BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]         HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Synchronizer
  logic rx_meta, rx_s;

  // Receiver FSM and datapath
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, frame_err;

  // FIFO
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, full_q, ovf_q, ferr_q;
  logic                  pop, accept, drop;

  // Two-flop synchronizer; idle-high reset avoids a false start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.UART_IN;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: mid-bit sampling driven by a single cycle counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be decoded as a stream of frames.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  always_comb begin
    pop    = bus.RD_EN && !empty_q;
    accept = push && (!full_q || pop);
    drop   = push && full_q && !pop;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy, registered flags and error pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH_CNT);
      ovf_q   <= drop;
      ferr_q  <= frame_err;
    end
  end

  // Storage; cleared on reset so RD_DATA reads 0x00 afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[wr_ptr] <= shift_q;
    end
  end

  assign bus.RD_DATA   = mem[rd_ptr];
  assign bus.EMPTY     = empty_q;
  assign bus.FULL      = full_q;
  assign bus.COUNT     = count_q;
  assign bus.FRAME_ERR = ferr_q;
  assign bus.OVERFLOW  = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Bit period is shortened to keep the run short;
// glitch and break durations are scaled to the same proportions.
module tb_uart_rx_fifo;

  localparam int C  = 32;
  localparam int H  = C / 2;
  localparam int DL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         cyc = 0;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(C), .DEPTH_LOG2(DL)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int model_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int fall_cyc = -1;
  int t_fall = 0;
  bit mon_on = 1'b0;
  bit prev_empty = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: pulse counting, EMPTY fall time, flag/COUNT consistency.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.FRAME_ERR) ferr_cnt++;
      if (bus.OVERFLOW) ovf_cnt++;
      if (prev_empty && !bus.EMPTY && fall_cyc < 0) fall_cyc = cyc;
      prev_empty = bus.EMPTY;
      check("empty_vs_count", 32'(bus.EMPTY), 32'(bus.COUNT == 0));
      check("full_vs_count", 32'(bus.FULL), 32'(bus.COUNT == 16));
    end
  end

  // Driver: one 8N1 frame, optional bad stop bit held low for extra cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int extra_low);
    bus.UART_IN = 1'b0;
    t_fall = cyc;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.UART_IN = b[i];
      repeat (C) @(negedge clk);
    end
    bus.UART_IN = stop_val;
    repeat (C) @(negedge clk);
    if (!stop_val) repeat (extra_low) @(negedge clk);
    bus.UART_IN = 1'b1;
    if (stop_val) begin
      if (model_cnt < 16) begin
        exp_q.push_back(b);
        model_cnt++;
      end
    end
  endtask

  // Driver: pop one byte and compare it with the scoreboard head.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_not_empty"}, 32'(bus.EMPTY), 32'd0);
      check({tag, "_rd_data"}, 32'(bus.RD_DATA), 32'(e));
      bus.RD_EN = 1'b1;
      @(negedge clk);
      bus.RD_EN = 1'b0;
      model_cnt--;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [6];
    int lat;
    prog = '{8'h2B, 8'h2B, 8'h2E, 8'h5B, 8'h2D, 8'h5D};

    // Reset
    bus.UART_IN = 1'b1;
    bus.RD_EN   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    check("rst_empty", 32'(bus.EMPTY), 32'd1);
    check("rst_full", 32'(bus.FULL), 32'd0);
    check("rst_count", 32'(bus.COUNT), 32'd0);
    check("rst_rd_data", 32'(bus.RD_DATA), 32'h00);
    check("rst_frame_err", 32'(bus.FRAME_ERR), 32'd0);
    check("rst_overflow", 32'(bus.OVERFLOW), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    idle(C);

    // Single byte with latency window
    fall_cyc = -1;
    send_frame(8'h2B, 1'b1, 0);
    lat = fall_cyc - t_fall;
    check("t1_latency_in_window",
          32'((fall_cyc >= 0) && (lat >= 4 + H + 9 * C - 2) && (lat <= 4 + H + 9 * C + 2)), 32'd1);
    check("t1_count", 32'(bus.COUNT), 32'd1);
    pop_check("t1");
    check("t1_empty_after_pop", 32'(bus.EMPTY), 32'd1);
    check("t1_count_after_pop", 32'(bus.COUNT), 32'd0);

    // Back-to-back program, no reads
    for (int i = 0; i < 6; i++) send_frame(prog[i], 1'b1, 0);
    check("t2_count", 32'(bus.COUNT), 32'd6);
    for (int i = 0; i < 6; i++) pop_check("t2");
    check("t2_empty", 32'(bus.EMPTY), 32'd1);

    // Glitch shorter than half a bit
    ferr_cnt = 0;
    bus.UART_IN = 1'b0;
    idle(C / 4);
    bus.UART_IN = 1'b1;
    idle(2 * C);
    check("t3_count", 32'(bus.COUNT), 32'd0);
    check("t3_no_frame_err", 32'(ferr_cnt), 32'd0);
    check("t3_state_idle", 32'(dbg_state), 32'd0);
    send_frame(8'h3E, 1'b1, 0);
    pop_check("t3");

    // Bad stop bit followed by a break
    ferr_cnt = 0;
    send_frame(8'h3C, 1'b0, 2 * C + $urandom_range(0, C));
    check("t4_frame_err_once", 32'(ferr_cnt), 32'd1);
    check("t4_count", 32'(bus.COUNT), 32'd0);
    idle(2 * C);
    check("t4_state_idle", 32'(dbg_state), 32'd0);
    check("t4_single_pulse", 32'(ferr_cnt), 32'd1);
    send_frame(8'h3C, 1'b1, 0);
    pop_check("t4");

    // Overflow and pointer wrap
    ovf_cnt = 0;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 0);
    check("t5_full", 32'(bus.FULL), 32'd1);
    check("t5_count", 32'(bus.COUNT), 32'd16);
    check("t5_overflow_once", 32'(ovf_cnt), 32'd1);
    for (int i = 0; i < 16; i++) pop_check("t5");
    check("t5_empty", 32'(bus.EMPTY), 32'd1);
    send_frame(8'h41, 1'b1, 0);
    pop_check("t5_wrap");

    // Reset mid-frame with a byte already buffered
    send_frame(8'h2B, 1'b1, 0);
    check("t6_pre_not_empty", 32'(bus.EMPTY), 32'd0);
    bus.UART_IN = 1'b0;
    idle(C);
    for (int i = 0; i < 3; i++) begin
      bus.UART_IN = prog[5][i];
      idle(C);
    end
    bus.UART_IN = prog[5][3];
    idle(H);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.UART_IN = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    check("t6_empty", 32'(bus.EMPTY), 32'd1);
    check("t6_full", 32'(bus.FULL), 32'd0);
    check("t6_count", 32'(bus.COUNT), 32'd0);
    check("t6_rd_data", 32'(bus.RD_DATA), 32'h00);
    check("t6_frame_err", 32'(bus.FRAME_ERR), 32'd0);
    check("t6_overflow", 32'(bus.OVERFLOW), 32'd0);
    check("t6_state", 32'(dbg_state), 32'd0);
    idle(12 * C);
    check("t6_no_push", 32'(bus.COUNT), 32'd0);
    send_frame(8'h5D, 1'b1, 0);
    pop_check("t6");
    check("t6_final_empty", 32'(bus.EMPTY), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial-to-byte receiver for the board's UART input line, with a small first-word-fall-through byte buffer. It sits between the `UART_IN` pin and the program loader. It accepts the brainfxck source stream (8N1, 115200 baud at 100 MHz) and presents received bytes in arrival order. Framing errors and buffer overflows are reported as single-cycle pulses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit. Must be ≥ 4.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^`DEPTH_LOG2` bytes (16).

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `UART_IN`  in  1  asynchronous serial line; idle high.
- `RD_EN`  in  1  pop request; ignored when `EMPTY`=1.
- `RD_DATA`  out  8  head-of-FIFO byte; valid while `EMPTY`=0.
- `EMPTY`  out  1  FIFO holds no bytes.
- `FULL`  out  1  FIFO holds 2^`DEPTH_LOG2` bytes.
- `COUNT`  out  `DEPTH_LOG2`+1  number of stored bytes.
- `FRAME_ERR`  out  1  one-cycle pulse: stop bit sampled low.
- `OVERFLOW`  out  1  one-cycle pulse: received byte dropped because FIFO full.

## Operation
- Input synchronizer: two flops on `UART_IN`. Both reset to 1. All decisions use the second flop output (`rx_s`).
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rx_s`=0, clear the bit counter and go to START.
  - START: after `CLKS_PER_BIT/2` cycles (integer division), sample `rx_s`.
    - 0: go to DATA.
    - 1: glitch; return to IDLE and push nothing.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - 1: push byte, go to IDLE.
    - 0: pulse `FRAME_ERR`, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- FIFO: circular buffer with `DEPTH_LOG2`-bit read and write pointers that wrap modulo depth. `COUNT` tracks occupancy.
  - Push when not full: write at the write pointer, advance it.
  - Push when full, no pop that cycle: byte dropped, pulse `OVERFLOW`, state unchanged.
  - Push when full with a pop the same cycle: the pop frees a slot; the push is accepted; `COUNT` is unchanged; no `OVERFLOW`.
  - Push and pop same cycle when not empty: both happen; `COUNT` is unchanged.
  - Pop when empty: no effect.
- `RD_DATA` always shows the entry at the read pointer (show-ahead). Its value when `EMPTY`=1 is don't-care.
- Reset (any cycle, including mid-frame) forces:
  - FSM to IDLE; all counters, shift register and pointers to 0.
  - `EMPTY`=1, `FULL`=0, `COUNT`=0, `FRAME_ERR`=0, `OVERFLOW`=0, `RD_DATA`=0x00.
  - A frame in progress is abandoned.

## Timing
- Synchronizer latency: 2 cycles from a pin edge to `rx_s`.
- Stop-bit sample occurs 2 + 1 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the `UART_IN` falling edge of the start bit. The bench accepts ±2 cycles.
- Push becomes visible one cycle after the stop-bit sample:
  - `EMPTY` falls, `COUNT` increments, and `RD_DATA` is valid on that same edge.
- Pop: `RD_EN`=1 at edge N. At N+1, `RD_DATA` shows the next entry and `COUNT` is decremented.
- `FRAME_ERR` and `OVERFLOW` are high for exactly one cycle, aligned with the stop-bit sample +1.
- `FULL` and `EMPTY` are registered and consistent with `COUNT` in every cycle.
- Back-to-back frames: the start bit is accepted on the first low `rx_s` after returning to IDLE. This is at most `CLKS_PER_BIT/2` cycles into the stop bit, so no frame is missed at full line rate.

## Test plan
- Single byte '+' (0x2B, 8N1, 868-cycle bits, idle high) -> `EMPTY` falls within the timing window; `RD_DATA`=0x2B, `COUNT`=1. After one `RD_EN` pulse -> `EMPTY`=1, `COUNT`=0.
- Program "++.[-]" sent back-to-back with no reads -> `COUNT`=6. Pops yield 0x2B, 0x2B, 0x2E, 0x5B, 0x2D, 0x5D in order, then `EMPTY`=1.
- Glitch: `UART_IN` low for 200 cycles, then high -> no push, no `FRAME_ERR`, FSM back in IDLE. A following 0x3E is received correctly.
- Bad stop bit: 0x3C sent with stop bit 0, held low 2000 cycles -> exactly one `FRAME_ERR` pulse, `COUNT`=0. After the line returns high, 0x3C with a valid stop bit -> `RD_DATA`=0x3C.
- Overflow: 17 frames 0x00..0x10, no reads -> `FULL`=1, `COUNT`=16, one `OVERFLOW` pulse on the 17th. Pops return 0x00..0x0F; the pointer wrap is verified by pushing 0x41 afterward and reading it back.
- Reset mid-frame: assert `RST` for one cycle during the 4th data bit of 0x5D -> all outputs return to reset values and no byte is pushed. The next full 0x5D frame -> `RD_DATA`=0x5D.
